// File: rtl/sirv_tl_pkg.sv
`default_nettype none
// ============================================================================
// sirv_tl_pkg : shared TileLink A-channel constants, repeater state, helpers
// Rev 1.0
// ============================================================================
package sirv_tl_pkg;

    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } tl_rep_state_e;

    function automatic int tl_bytes(input int dw);
        return dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sirv_tl_repeater_n.sv
`default_nettype none
// ============================================================================
// sirv_tl_repeater_n : count-driven TL-A repeater with beat counter and address step
// Rev 1.0
// ============================================================================
module sirv_tl_repeater_n
    import sirv_tl_pkg::*;
#(
    parameter int AW       = 30,
    parameter int DW       = 32,
    parameter int SW       = 2,
    parameter int CW       = 4,
    parameter int INC_ADDR = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              io_flush,
    input  logic [CW-1:0]     io_repeat_cnt,
    output logic              io_full,
    output logic [CW-1:0]     io_beats_left,
    output logic              io_enq_ready,
    input  logic              io_enq_valid,
    input  logic [2:0]        io_enq_bits_opcode,
    input  logic [2:0]        io_enq_bits_param,
    input  logic [2:0]        io_enq_bits_size,
    input  logic [SW-1:0]     io_enq_bits_source,
    input  logic [AW-1:0]     io_enq_bits_address,
    input  logic [DW/8-1:0]   io_enq_bits_mask,
    input  logic [DW-1:0]     io_enq_bits_data,
    input  logic              io_deq_ready,
    output logic              io_deq_valid,
    output logic [2:0]        io_deq_bits_opcode,
    output logic [2:0]        io_deq_bits_param,
    output logic [2:0]        io_deq_bits_size,
    output logic [SW-1:0]     io_deq_bits_source,
    output logic [AW-1:0]     io_deq_bits_address,
    output logic [DW/8-1:0]   io_deq_bits_mask,
    output logic [DW-1:0]     io_deq_bits_data,
    output logic              io_deq_last
);

    localparam int          BYTES = tl_bytes(DW);
    localparam int          SHIFT = $clog2(BYTES);
    localparam logic [CW-1:0] ONE = CW'(1);

    tl_rep_state_e     r_state;
    logic [CW-1:0]     r_rem;
    logic [CW-1:0]     r_idx;
    logic [2:0]        r_opcode;
    logic [2:0]        r_param;
    logic [2:0]        r_size;
    logic [SW-1:0]     r_source;
    logic [AW-1:0]     r_address;
    logic [DW/8-1:0]   r_mask;
    logic [DW-1:0]     r_data;

    logic              w_hold;
    logic [AW-1:0]     w_hold_address;

    assign w_hold = (r_state == ST_HOLD);

    // Replay address wraps naturally at AW bits.
    if (INC_ADDR != 0) begin : g_inc_addr
        assign w_hold_address = r_address + (AW'(r_idx) << SHIFT);
    end else begin : g_fixed_addr
        assign w_hold_address = r_address;
    end

    assign io_full             = w_hold;
    assign io_beats_left       = w_hold ? (r_rem - ONE) : '0;
    assign io_enq_ready        = w_hold ? 1'b0 : (io_deq_ready & ~io_flush);
    assign io_deq_valid        = w_hold ? ~io_flush : (io_enq_valid & ~io_flush);
    assign io_deq_bits_opcode  = w_hold ? r_opcode  : io_enq_bits_opcode;
    assign io_deq_bits_param   = w_hold ? r_param   : io_enq_bits_param;
    assign io_deq_bits_size    = w_hold ? r_size    : io_enq_bits_size;
    assign io_deq_bits_source  = w_hold ? r_source  : io_enq_bits_source;
    assign io_deq_bits_address = w_hold ? w_hold_address : io_enq_bits_address;
    assign io_deq_bits_mask    = w_hold ? r_mask    : io_enq_bits_mask;
    assign io_deq_bits_data    = w_hold ? r_data    : io_enq_bits_data;
    assign io_deq_last         = w_hold ? (r_rem == ONE) : (io_repeat_cnt == '0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_idx     <= '0;
            r_opcode  <= '0;
            r_param   <= '0;
            r_size    <= '0;
            r_source  <= '0;
            r_address <= '0;
            r_mask    <= '0;
            r_data    <= '0;
        end else if (io_flush) begin
            // Saved fields are intentionally left stale; only the replay is aborted.
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_enq_valid && io_enq_ready && (io_repeat_cnt != '0)) begin
                        r_state   <= ST_HOLD;
                        r_rem     <= io_repeat_cnt;
                        r_idx     <= ONE;
                        r_opcode  <= io_enq_bits_opcode;
                        r_param   <= io_enq_bits_param;
                        r_size    <= io_enq_bits_size;
                        r_source  <= io_enq_bits_source;
                        r_address <= io_enq_bits_address;
                        r_mask    <= io_enq_bits_mask;
                        r_data    <= io_enq_bits_data;
                    end
                end
                ST_HOLD: begin
                    if (io_deq_ready) begin
                        if (r_rem == ONE) begin
                            r_state <= ST_IDLE;
                            r_rem   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_rem <= r_rem - ONE;
                            r_idx <= r_idx + ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rem   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sirv_tl_repeater_n.sv
`default_nettype none
// ============================================================================
// tb_sirv_tl_repeater_n : directed self-checking bench for the TL-A repeater
// Rev 1.0
// ============================================================================
module tb_sirv_tl_repeater_n;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int CW = 4;

    logic            clock;
    logic            rst_n;
    logic            flush;
    logic [CW-1:0]   repeat_cnt;
    logic            enq_valid;
    logic [2:0]      enq_opcode;
    logic [2:0]      enq_param;
    logic [2:0]      enq_size;
    logic [SW-1:0]   enq_source;
    logic [AW-1:0]   enq_address;
    logic [DW/8-1:0] enq_mask;
    logic [DW-1:0]   enq_data;
    logic            deq_ready;

    logic            full, full_f;
    logic [CW-1:0]   beats_left, beats_left_f;
    logic            enq_ready, enq_ready_f;
    logic            deq_valid, deq_valid_f;
    logic [2:0]      deq_opcode, deq_opcode_f;
    logic [2:0]      deq_param, deq_param_f;
    logic [2:0]      deq_size, deq_size_f;
    logic [SW-1:0]   deq_source, deq_source_f;
    logic [AW-1:0]   deq_address, deq_address_f;
    logic [DW/8-1:0] deq_mask, deq_mask_f;
    logic [DW-1:0]   deq_data, deq_data_f;
    logic            deq_last, deq_last_f;

    int checks;
    int failures;

    sirv_tl_repeater_n #(
        .AW(AW), .DW(DW), .SW(SW), .CW(CW), .INC_ADDR(1)
    ) dut (
        .clock(clock), .rst_n(rst_n), .io_flush(flush), .io_repeat_cnt(repeat_cnt),
        .io_full(full), .io_beats_left(beats_left),
        .io_enq_ready(enq_ready), .io_enq_valid(enq_valid),
        .io_enq_bits_opcode(enq_opcode), .io_enq_bits_param(enq_param),
        .io_enq_bits_size(enq_size), .io_enq_bits_source(enq_source),
        .io_enq_bits_address(enq_address), .io_enq_bits_mask(enq_mask),
        .io_enq_bits_data(enq_data),
        .io_deq_ready(deq_ready), .io_deq_valid(deq_valid),
        .io_deq_bits_opcode(deq_opcode), .io_deq_bits_param(deq_param),
        .io_deq_bits_size(deq_size), .io_deq_bits_source(deq_source),
        .io_deq_bits_address(deq_address), .io_deq_bits_mask(deq_mask),
        .io_deq_bits_data(deq_data), .io_deq_last(deq_last)
    );

    sirv_tl_repeater_n #(
        .AW(AW), .DW(DW), .SW(SW), .CW(CW), .INC_ADDR(0)
    ) dut_fixed (
        .clock(clock), .rst_n(rst_n), .io_flush(flush), .io_repeat_cnt(repeat_cnt),
        .io_full(full_f), .io_beats_left(beats_left_f),
        .io_enq_ready(enq_ready_f), .io_enq_valid(enq_valid),
        .io_enq_bits_opcode(enq_opcode), .io_enq_bits_param(enq_param),
        .io_enq_bits_size(enq_size), .io_enq_bits_source(enq_source),
        .io_enq_bits_address(enq_address), .io_enq_bits_mask(enq_mask),
        .io_enq_bits_data(enq_data),
        .io_deq_ready(deq_ready), .io_deq_valid(deq_valid_f),
        .io_deq_bits_opcode(deq_opcode_f), .io_deq_bits_param(deq_param_f),
        .io_deq_bits_size(deq_size_f), .io_deq_bits_source(deq_source_f),
        .io_deq_bits_address(deq_address_f), .io_deq_bits_mask(deq_mask_f),
        .io_deq_bits_data(deq_data_f), .io_deq_last(deq_last_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_req(input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [CW-1:0] cnt);
        enq_valid   = 1'b1;
        enq_opcode  = op;
        enq_param   = 3'd0;
        enq_size    = 3'd2;
        enq_source  = 2'd1;
        enq_address = addr;
        enq_mask    = 4'hF;
        enq_data    = data;
        repeat_cnt  = cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; deq_ready = 1'b1;
        set_req(3'd4, 30'h123, 32'h0, 4'd0);
        @(negedge clock); #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full); end
        checks++; if (beats_left !== 4'd0) begin failures++; $display("FAIL reset_beats_left got=%0h exp=0", beats_left); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready_hi got=%0h exp=1", enq_ready); end
        checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL reset_deq_valid_hi got=%0h exp=1", deq_valid); end
        checks++; if (deq_address !== 30'h123) begin failures++; $display("FAIL reset_deq_addr got=%0h exp=123", deq_address); end
        deq_ready = 1'b0; enq_valid = 1'b0; #1;
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL reset_enq_ready_lo got=%0h exp=0", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid_lo got=%0h exp=0", deq_valid); end
        @(negedge clock); rst_n = 1'b1; deq_ready = 1'b1;
    endtask

    task automatic test_pass_through();
        @(negedge clock);
        set_req(3'd4, 30'h100, 32'h0, 4'd0); #1;
        checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL pt_deq_valid got=%0h exp=1", deq_valid); end
        checks++; if (deq_address !== 30'h100) begin failures++; $display("FAIL pt_addr got=%0h exp=100", deq_address); end
        checks++; if (deq_opcode !== 3'd4) begin failures++; $display("FAIL pt_opcode got=%0h exp=4", deq_opcode); end
        checks++; if (deq_last !== 1'b1) begin failures++; $display("FAIL pt_last got=%0h exp=1", deq_last); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL pt_enq_ready got=%0h exp=1", enq_ready); end
        @(negedge clock); enq_valid = 1'b0; #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL pt_full_after got=%0h exp=0", full); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL pt_deq_valid_after got=%0h exp=0", deq_valid); end
    endtask

    task automatic test_count_repeat();
        @(negedge clock);
        deq_ready = 1'b1;
        set_req(3'd0, 30'h200, 32'hDEADBEEF, 4'd3); #1;
        checks++; if (deq_address !== 30'h200) begin failures++; $display("FAIL cr_beat0_addr got=%0h exp=200", deq_address); end
        checks++; if (deq_last !== 1'b0) begin failures++; $display("FAIL cr_beat0_last got=%0h exp=0", deq_last); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL cr_beat0_full got=%0h exp=0", full); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock); enq_valid = 1'b0; #1;
            checks++; if (full !== 1'b1) begin failures++; $display("FAIL cr_full beat=%0d got=%0h exp=1", k, full); end
            checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL cr_deq_valid beat=%0d got=%0h exp=1", k, deq_valid); end
            checks++; if (deq_address !== 30'(32'h200 + 4 * k)) begin failures++; $display("FAIL cr_addr beat=%0d got=%0h exp=%0h", k, deq_address, 32'h200 + 4 * k); end
            checks++; if (deq_data !== 32'hDEADBEEF) begin failures++; $display("FAIL cr_data beat=%0d got=%0h exp=deadbeef", k, deq_data); end
            checks++; if (deq_opcode !== 3'd0) begin failures++; $display("FAIL cr_opcode beat=%0d got=%0h exp=0", k, deq_opcode); end
            checks++; if (deq_last !== (k == 3)) begin failures++; $display("FAIL cr_last beat=%0d got=%0h exp=%0h", k, deq_last, (k == 3)); end
            checks++; if (beats_left !== 4'(3 - k)) begin failures++; $display("FAIL cr_beats_left beat=%0d got=%0h exp=%0h", k, beats_left, 3 - k); end
            checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL cr_enq_ready beat=%0d got=%0h exp=0", k, enq_ready); end
        end
        @(negedge clock); #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL cr_full_after got=%0h exp=0", full); end
    endtask

    task automatic test_backpressure();
        logic pat [0:7];
        int k;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clock);
        deq_ready = 1'b1;
        set_req(3'd0, 30'h300, 32'hCAFEF00D, 4'd3); #1;
        checks++; if (deq_address !== 30'h300) begin failures++; $display("FAIL bp_beat0_addr got=%0h exp=300", deq_address); end
        k = 1;
        for (int i = 0; i < 8 && k <= 3; i++) begin
            @(negedge clock); enq_valid = 1'b0; deq_ready = pat[i]; #1;
            checks++; if (deq_address !== 30'(32'h300 + 4 * k)) begin failures++; $display("FAIL bp_addr cyc=%0d got=%0h exp=%0h", i, deq_address, 32'h300 + 4 * k); end
            checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL bp_enq_ready cyc=%0d got=%0h exp=0", i, enq_ready); end
            checks++; if (full !== 1'b1) begin failures++; $display("FAIL bp_full cyc=%0d got=%0h exp=1", i, full); end
            checks++; if (deq_last !== (k == 3)) begin failures++; $display("FAIL bp_last cyc=%0d got=%0h exp=%0h", i, deq_last, (k == 3)); end
            if (deq_ready) k++;
        end
        @(negedge clock); deq_ready = 1'b1; #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL bp_full_after got=%0h exp=0", full); end
    endtask

    task automatic test_wrap_and_fixed();
        @(negedge clock);
        deq_ready = 1'b1;
        set_req(3'd4, 30'h3FFFFFFC, 32'h0, 4'd1); #1;
        checks++; if (deq_address !== 30'h3FFFFFFC) begin failures++; $display("FAIL wrap_beat0 got=%0h exp=3ffffffc", deq_address); end
        @(negedge clock); enq_valid = 1'b0; #1;
        checks++; if (deq_address !== 30'h0) begin failures++; $display("FAIL wrap_beat1 got=%0h exp=0", deq_address); end
        checks++; if (deq_last !== 1'b1) begin failures++; $display("FAIL wrap_last got=%0h exp=1", deq_last); end
        checks++; if (deq_address_f !== 30'h3FFFFFFC) begin failures++; $display("FAIL fixed_wrap_beat1 got=%0h exp=3ffffffc", deq_address_f); end
        @(negedge clock); #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL wrap_full_after got=%0h exp=0", full); end

        set_req(3'd4, 30'h40, 32'h0, 4'd2); #1;
        checks++; if (deq_address_f !== 30'h40) begin failures++; $display("FAIL fixed_beat0 got=%0h exp=40", deq_address_f); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock); enq_valid = 1'b0; #1;
            checks++; if (deq_address_f !== 30'h40) begin failures++; $display("FAIL fixed_addr beat=%0d got=%0h exp=40", k, deq_address_f); end
            checks++; if (deq_last_f !== (k == 2)) begin failures++; $display("FAIL fixed_last beat=%0d got=%0h exp=%0h", k, deq_last_f, (k == 2)); end
            checks++; if (deq_address !== 30'(32'h40 + 4 * k)) begin failures++; $display("FAIL inc_addr beat=%0d got=%0h exp=%0h", k, deq_address, 32'h40 + 4 * k); end
        end
        @(negedge clock); #1;
        checks++; if (full_f !== 1'b0) begin failures++; $display("FAIL fixed_full_after got=%0h exp=0", full_f); end
    endtask

    task automatic test_flush();
        @(negedge clock);
        deq_ready = 1'b1;
        set_req(3'd1, 30'h500, 32'h11223344, 4'd5); #1;
        checks++; if (deq_address !== 30'h500) begin failures++; $display("FAIL fl_beat0 got=%0h exp=500", deq_address); end
        @(negedge clock); enq_valid = 1'b0; #1;
        checks++; if (deq_address !== 30'h504) begin failures++; $display("FAIL fl_beat1 got=%0h exp=504", deq_address); end
        checks++; if (beats_left !== 4'd4) begin failures++; $display("FAIL fl_beats_left got=%0h exp=4", beats_left); end
        @(negedge clock); flush = 1'b1; #1;
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL fl_deq_valid got=%0h exp=0", deq_valid); end
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fl_enq_ready got=%0h exp=0", enq_ready); end
        @(negedge clock); flush = 1'b0;
        set_req(3'd4, 30'h600, 32'h0, 4'd0); #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL fl_full_after got=%0h exp=0", full); end
        checks++; if (beats_left !== 4'd0) begin failures++; $display("FAIL fl_beats_left_after got=%0h exp=0", beats_left); end
        checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL fl_new_valid got=%0h exp=1", deq_valid); end
        checks++; if (deq_address !== 30'h600) begin failures++; $display("FAIL fl_new_addr got=%0h exp=600", deq_address); end
        checks++; if (deq_last !== 1'b1) begin failures++; $display("FAIL fl_new_last got=%0h exp=1", deq_last); end
        @(negedge clock); flush = 1'b1;
        set_req(3'd4, 30'h700, 32'h0, 4'd2); #1;
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fl_idle_enq_ready got=%0h exp=0", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL fl_idle_deq_valid got=%0h exp=0", deq_valid); end
        @(negedge clock); flush = 1'b0; enq_valid = 1'b0; #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL fl_idle_no_capture got=%0h exp=0", full); end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        deq_ready = 1'b1;
        set_req(3'd4, 30'h800, 32'h0, 4'd4);
        @(negedge clock); enq_valid = 1'b0; #1;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ar_full_before got=%0h exp=1", full); end
        checks++; if (beats_left !== 4'd3) begin failures++; $display("FAIL ar_beats_left_before got=%0h exp=3", beats_left); end
        #1 rst_n = 1'b0; #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL ar_full got=%0h exp=0", full); end
        checks++; if (beats_left !== 4'd0) begin failures++; $display("FAIL ar_beats_left got=%0h exp=0", beats_left); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL ar_deq_valid got=%0h exp=0", deq_valid); end
        @(negedge clock); rst_n = 1'b1;
        set_req(3'd4, 30'h900, 32'h0, 4'd0); #1;
        checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL ar_pt_valid got=%0h exp=1", deq_valid); end
        checks++; if (deq_address !== 30'h900) begin failures++; $display("FAIL ar_pt_addr got=%0h exp=900", deq_address); end
        checks++; if (deq_last !== 1'b1) begin failures++; $display("FAIL ar_pt_last got=%0h exp=1", deq_last); end
        @(negedge clock); enq_valid = 1'b0; #1;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL ar_full_after got=%0h exp=0", full); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pass_through();
        test_count_repeat();
        test_backpressure();
        test_wrap_and_fixed();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
